// File: rtl/mem_stage_if.sv
// Bundle-level connection between the memory stage and its neighbours:
// the execute hand-off, writeback hand-off, data-SRAM response and decode feedback.
interface mem_stage_if #(
    parameter int unsigned EXE_BUS_W = 166,
    parameter int unsigned WB_BUS_W  = 160
);
    logic                 exe_to_mem_valid;
    logic [EXE_BUS_W-1:0] exe_to_mem_bus;
    logic                 mem_allow;
    logic                 wb_allow;
    logic                 wb_exception;
    logic                 data_sram_data_ok;
    logic [31:0]          data_sram_rdata;
    logic                 mem_to_wb_valid;
    logic [WB_BUS_W-1:0]  mem_to_wb_bus;
    logic [4:0]           mem_dest_bus;
    logic [31:0]          mem_value_bus;
    logic                 mem_load_wait;
    logic                 mem_csr_re_bus;
    logic                 mem_exception;

    // Environment side: drives execute, writeback and SRAM inputs.
    modport master (
        output exe_to_mem_valid, exe_to_mem_bus, wb_allow, wb_exception,
               data_sram_data_ok, data_sram_rdata,
        input  mem_allow, mem_to_wb_valid, mem_to_wb_bus, mem_dest_bus,
               mem_value_bus, mem_load_wait, mem_csr_re_bus, mem_exception
    );

    // Stage side.
    modport slave (
        input  exe_to_mem_valid, exe_to_mem_bus, wb_allow, wb_exception,
               data_sram_data_ok, data_sram_rdata,
        output mem_allow, mem_to_wb_valid, mem_to_wb_bus, mem_dest_bus,
               mem_value_bus, mem_load_wait, mem_csr_re_bus, mem_exception
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response, aligns/extends load data,
// forwards to decode, and drops responses belonging to flushed requests.
module mem_stage #(
    parameter int unsigned EXE_BUS_W = 166,
    parameter int unsigned WB_BUS_W  = 160
) (
    input  logic         clk,
    input  logic         reset,
    mem_stage_if.slave   mif
);

    localparam int unsigned DISC_W   = 2;
    localparam int unsigned DATA_W   = 32;

    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
        logic        ld_b;
        logic        ld_bu;
        logic        ld_h;
        logic        ld_hu;
        logic        ld_w;
        logic        csr_re;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic [13:0] csr_num;
        logic        syscall;
        logic        ertn;
        logic        rdcntvh;
        logic        rdcntvl;
        logic        brk;
        logic        ine;
        logic        intr;
        logic        adef;
        logic        ale;
        logic        req_sent;
    } exe_bus_t;

    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        csr_re;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic [13:0] csr_num;
        logic        syscall;
        logic        ertn;
        logic        rdcntvh;
        logic        rdcntvl;
        logic        brk;
        logic        ine;
        logic        intr;
        logic        adef;
        logic        ale;
    } wb_bus_t;

    // State registers and their next values
    logic              r_mem_valid,   w_mem_valid_nxt;
    exe_bus_t          r_bus,         w_bus_nxt;
    logic [DATA_W-1:0] r_data_buf,    w_data_buf_nxt;
    logic              r_data_buf_v,  w_data_buf_v_nxt;
    logic [DISC_W-1:0] r_discard_cnt, w_discard_nxt;

    logic [EXE_BUS_W-1:0] w_exe_raw;
    exe_bus_t             w_exe_in;
    wb_bus_t              w_wb;

    logic              w_disc_zero;
    logic              w_mem_go;
    logic              w_mem_allow;
    logic              w_latch;
    logic              w_leave;
    logic              w_buf_set;
    logic              w_disc_inc;
    logic              w_disc_dec;
    logic [DATA_W-1:0] w_ld_src;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ld_ext;
    logic [DATA_W-1:0] w_wdata;

    assign w_exe_raw = mif.exe_to_mem_bus;
    assign w_exe_in  = exe_bus_t'(w_exe_raw);

    // Handshake: a bundle with an issued request may only leave once its own response is here.
    assign w_disc_zero = (r_discard_cnt == DISC_W'(0));
    assign w_mem_go    = ~r_bus.req_sent | r_data_buf_v | (mif.data_sram_data_ok & w_disc_zero);
    assign w_mem_allow = ~r_mem_valid | (w_mem_go & mif.wb_allow);
    assign w_latch     = mif.exe_to_mem_valid & w_mem_allow;
    assign w_leave     = r_mem_valid & w_mem_go & mif.wb_allow;

    // Hold an early response when writeback is stalled.
    assign w_buf_set = mif.data_sram_data_ok & r_mem_valid & r_bus.req_sent & ~r_data_buf_v
                     & w_disc_zero & ~(w_mem_go & mif.wb_allow) & ~mif.wb_exception;

    // Flushed-but-outstanding requests owe us one response each; those responses are dropped.
    assign w_disc_inc = mif.wb_exception & r_mem_valid & r_bus.req_sent & ~r_data_buf_v
                      & ~(mif.data_sram_data_ok & w_disc_zero);
    assign w_disc_dec = mif.data_sram_data_ok & ~w_disc_zero;

    // Load alignment and extension
    always_comb begin
        w_ld_src = r_data_buf_v ? r_data_buf : mif.data_sram_rdata;
        case (r_bus.result[1:0])
            2'd0:    w_byte = w_ld_src[7:0];
            2'd1:    w_byte = w_ld_src[15:8];
            2'd2:    w_byte = w_ld_src[23:16];
            default: w_byte = w_ld_src[31:24];
        endcase
        w_half   = r_bus.result[1] ? w_ld_src[31:16] : w_ld_src[15:0];
        w_ld_ext = '0;
        if (r_bus.ld_b) begin
            w_ld_ext = {{24{w_byte[7]}}, w_byte};
        end else if (r_bus.ld_bu) begin
            w_ld_ext = {24'd0, w_byte};
        end else if (r_bus.ld_h) begin
            w_ld_ext = {{16{w_half[15]}}, w_half};
        end else if (r_bus.ld_hu) begin
            w_ld_ext = {16'd0, w_half};
        end else if (r_bus.ld_w) begin
            w_ld_ext = w_ld_src;
        end
        w_wdata = r_bus.res_from_mem ? w_ld_ext : r_bus.result;
    end

    // Writeback bundle: load/request qualifiers stripped, result replaced by final data
    always_comb begin
        w_wb              = '0;
        w_wb.res_from_mem = r_bus.res_from_mem;
        w_wb.gr_we        = r_bus.gr_we;
        w_wb.dest         = r_bus.dest;
        w_wb.wdata        = w_wdata;
        w_wb.pc           = r_bus.pc;
        w_wb.csr_re       = r_bus.csr_re;
        w_wb.csr_we       = r_bus.csr_we;
        w_wb.csr_wmask    = r_bus.csr_wmask;
        w_wb.csr_wvalue   = r_bus.csr_wvalue;
        w_wb.csr_num      = r_bus.csr_num;
        w_wb.syscall      = r_bus.syscall;
        w_wb.ertn         = r_bus.ertn;
        w_wb.rdcntvh      = r_bus.rdcntvh;
        w_wb.rdcntvl      = r_bus.rdcntvl;
        w_wb.brk          = r_bus.brk;
        w_wb.ine          = r_bus.ine;
        w_wb.intr         = r_bus.intr;
        w_wb.adef         = r_bus.adef;
        w_wb.ale          = r_bus.ale;
    end

    // Next-state logic
    always_comb begin
        w_mem_valid_nxt  = r_mem_valid;
        w_bus_nxt        = r_bus;
        w_data_buf_nxt   = r_data_buf;
        w_data_buf_v_nxt = r_data_buf_v;
        w_discard_nxt    = r_discard_cnt;

        if (mif.wb_exception) begin
            w_mem_valid_nxt = 1'b0;
        end else if (w_mem_allow) begin
            w_mem_valid_nxt = mif.exe_to_mem_valid;
        end

        if (w_latch) begin
            w_bus_nxt = w_exe_in;
        end

        if (w_latch | w_leave | mif.wb_exception) begin
            w_data_buf_v_nxt = 1'b0;
        end else if (w_buf_set) begin
            w_data_buf_v_nxt = 1'b1;
        end

        if (w_buf_set) begin
            w_data_buf_nxt = mif.data_sram_rdata;
        end

        if (w_disc_inc & ~w_disc_dec) begin
            if (r_discard_cnt != DISC_W'(3)) begin
                w_discard_nxt = r_discard_cnt + DISC_W'(1);
            end
        end else if (~w_disc_inc & w_disc_dec) begin
            w_discard_nxt = r_discard_cnt - DISC_W'(1);
        end
    end

    // SRAM resets alongside us, so nothing is left to discard after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_valid   <= 1'b0;
            r_bus         <= '0;
            r_data_buf    <= '0;
            r_data_buf_v  <= 1'b0;
            r_discard_cnt <= '0;
        end else begin
            r_mem_valid   <= w_mem_valid_nxt;
            r_bus         <= w_bus_nxt;
            r_data_buf    <= w_data_buf_nxt;
            r_data_buf_v  <= w_data_buf_v_nxt;
            r_discard_cnt <= w_discard_nxt;
        end
    end

    assign mif.mem_allow       = w_mem_allow;
    assign mif.mem_to_wb_valid = r_mem_valid & w_mem_go;
    assign mif.mem_to_wb_bus   = WB_BUS_W'(w_wb);
    assign mif.mem_dest_bus    = (r_mem_valid & r_bus.gr_we) ? r_bus.dest : 5'd0;
    assign mif.mem_value_bus   = w_wdata;
    assign mif.mem_load_wait   = r_mem_valid & r_bus.res_from_mem & ~w_mem_go;
    assign mif.mem_csr_re_bus  = r_mem_valid & r_bus.csr_re;
    assign mif.mem_exception   = r_mem_valid & (r_bus.syscall | r_bus.ertn | r_bus.brk | r_bus.ine
                                              | r_bus.intr | r_bus.adef | r_bus.ale);

endmodule

// File: tb/tb_mem_stage.sv
// Scenario bench for mem_stage: writeback bundles are checked by a scoreboard monitor,
// forwarding/handshake outputs are checked inline by each scenario task.
module tb_mem_stage;

    localparam int unsigned EXE_W = 166;
    localparam int unsigned WB_W  = 160;

    localparam logic [4:0]  LD_B  = 5'b10000;
    localparam logic [4:0]  LD_BU = 5'b01000;
    localparam logic [4:0]  LD_H  = 5'b00100;
    localparam logic [4:0]  LD_HU = 5'b00010;
    localparam logic [4:0]  LD_W  = 5'b00001;
    localparam logic [4:0]  LD_NONE = 5'b00000;

    localparam logic [31:0] PC    = 32'h1C00_0040;
    localparam logic        CSRWE = 1'b1;
    localparam logic [31:0] WMASK = 32'hFFFF_0000;
    localparam logic [31:0] WVAL  = 32'hA5A5_5A5A;
    localparam logic [13:0] CNUM  = 14'h0123;
    // syscall, ertn, rdcntvh, rdcntvl, brk, ine, int, adef
    localparam logic [7:0]  MISC  = 8'b0001_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WB_W-1:0] exp_q[$];
    logic [WB_W-1:0] exp_wb;

    mem_stage_if #(.EXE_BUS_W(EXE_W), .WB_BUS_W(WB_W)) mif ();

    mem_stage #(.EXE_BUS_W(EXE_W), .WB_BUS_W(WB_W)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [EXE_W-1:0] mk_exe(input logic rfm, input logic we, input logic [4:0] dest,
                                                input logic [31:0] result, input logic [4:0] ld,
                                                input logic csr_re, input logic ale, input logic req_sent);
        mk_exe = {rfm, we, dest, result, PC, ld, csr_re, CSRWE, WMASK, WVAL, CNUM, MISC, ale, req_sent};
    endfunction

    function automatic logic [WB_W-1:0] mk_wb(input logic rfm, input logic we, input logic [4:0] dest,
                                              input logic [31:0] wdata, input logic csr_re, input logic ale);
        mk_wb = {rfm, we, dest, wdata, PC, csr_re, CSRWE, WMASK, WVAL, CNUM, MISC, ale};
    endfunction

    // Scoreboard: every accepted writeback transfer must match the oldest expectation.
    always @(negedge clk) begin
        #2;
        if (!reset && mif.mem_to_wb_valid === 1'b1 && mif.wb_allow === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got bundle %h with nothing expected", mif.mem_to_wb_bus);
            end else begin
                exp_wb = exp_q.pop_front();
                if (mif.mem_to_wb_bus !== exp_wb) begin
                    n_fail++;
                    $display("FAIL wb_bundle: got %h expected %h", mif.mem_to_wb_bus, exp_wb);
                end
            end
        end
    end

    task automatic drive_idle();
        mif.exe_to_mem_valid  = 1'b0;
        mif.exe_to_mem_bus    = '0;
        mif.wb_allow          = 1'b1;
        mif.wb_exception      = 1'b0;
        mif.data_sram_data_ok = 1'b0;
        mif.data_sram_rdata   = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (mif.mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", mif.mem_to_wb_valid); end
        n_checks++; if (mif.mem_to_wb_bus !== '0) begin n_fail++; $display("FAIL reset_bus: got %h expected 0", mif.mem_to_wb_bus); end
        n_checks++; if (mif.mem_dest_bus !== 5'd0) begin n_fail++; $display("FAIL reset_dest: got %h expected 0", mif.mem_dest_bus); end
        n_checks++; if (mif.mem_value_bus !== 32'd0) begin n_fail++; $display("FAIL reset_value: got %h expected 0", mif.mem_value_bus); end
        n_checks++; if (mif.mem_load_wait !== 1'b0) begin n_fail++; $display("FAIL reset_load_wait: got %b expected 0", mif.mem_load_wait); end
        n_checks++; if (mif.mem_csr_re_bus !== 1'b0) begin n_fail++; $display("FAIL reset_csr_re: got %b expected 0", mif.mem_csr_re_bus); end
        n_checks++; if (mif.mem_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exception: got %b expected 0", mif.mem_exception); end
    endtask

    task automatic test_alu();
        @(negedge clk);
        mif.exe_to_mem_valid = 1'b1;
        mif.exe_to_mem_bus   = mk_exe(1'b0, 1'b1, 5'd5, 32'h0000_1234, LD_NONE, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mk_wb(1'b0, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0));
        #1;
        n_checks++; if (mif.mem_allow !== 1'b1) begin n_fail++; $display("FAIL alu_allow: got %b expected 1", mif.mem_allow); end
        @(negedge clk);
        mif.exe_to_mem_valid = 1'b0;
        #1;
        n_checks++; if (mif.mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b expected 1", mif.mem_to_wb_valid); end
        n_checks++; if (mif.mem_dest_bus !== 5'd5) begin n_fail++; $display("FAIL alu_dest: got %0d expected 5", mif.mem_dest_bus); end
        n_checks++; if (mif.mem_value_bus !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_value: got %h expected 00001234", mif.mem_value_bus); end
        @(negedge clk);
        #1;
        n_checks++; if (mif.mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drained: got %b expected 0", mif.mem_to_wb_valid); end
    endtask

    task automatic test_ld_b_wait();
        @(negedge clk);
        mif.exe_to_mem_valid = 1'b1;
        mif.exe_to_mem_bus   = mk_exe(1'b1, 1'b1, 5'd7, 32'h0000_1003, LD_B, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(mk_wb(1'b1, 1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mif.exe_to_mem_valid = 1'b0;
            #1;
            n_checks++; if (mif.mem_load_wait !== 1'b1) begin n_fail++; $display("FAIL ldb_wait[%0d]: got %b expected 1", i, mif.mem_load_wait); end
            n_checks++; if (mif.mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL ldb_early_valid[%0d]: got %b expected 0", i, mif.mem_to_wb_valid); end
            n_checks++; if (mif.mem_allow !== 1'b0) begin n_fail++; $display("FAIL ldb_allow[%0d]: got %b expected 0", i, mif.mem_allow); end
            n_checks++; if (mif.mem_dest_bus !== 5'd7) begin n_fail++; $display("FAIL ldb_dest[%0d]: got %0d expected 7", i, mif.mem_dest_bus); end
        end
        @(negedge clk);
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h80FF_FFFF;
        #1;
        n_checks++; if (mif.mem_load_wait !== 1'b0) begin n_fail++; $display("FAIL ldb_wait_done: got %b expected 0", mif.mem_load_wait); end
        n_checks++; if (mif.mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL ldb_valid: got %b expected 1", mif.mem_to_wb_valid); end
        n_checks++; if (mif.mem_value_bus !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL ldb_value: got %h expected ffffff80", mif.mem_value_bus); end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_ld_hu_buffered();
        @(negedge clk);
        mif.wb_allow         = 1'b0;
        mif.exe_to_mem_valid = 1'b1;
        mif.exe_to_mem_bus   = mk_exe(1'b1, 1'b1, 5'd9, 32'h0000_2002, LD_HU, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(mk_wb(1'b1, 1'b1, 5'd9, 32'h0000_8001, 1'b0, 1'b0));
        @(negedge clk);
        mif.exe_to_mem_valid  = 1'b0;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h8001_0000;
        #1;
        n_checks++; if (mif.mem_allow !== 1'b0) begin n_fail++; $display("FAIL hu_allow_stalled: got %b expected 0", mif.mem_allow); end
        @(negedge clk);
        mif.data_sram_data_ok = 1'b0;
        mif.data_sram_rdata   = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (mif.mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL hu_buf_valid: got %b expected 1", mif.mem_to_wb_valid); end
        n_checks++; if (mif.mem_value_bus !== 32'h0000_8001) begin n_fail++; $display("FAIL hu_buf_value: got %h expected 00008001", mif.mem_value_bus); end
        n_checks++; if (mif.mem_load_wait !== 1'b0) begin n_fail++; $display("FAIL hu_buf_wait: got %b expected 0", mif.mem_load_wait); end
        @(negedge clk);
        mif.wb_allow = 1'b1;
        #1;
        n_checks++; if (mif.mem_value_bus !== 32'h0000_8001) begin n_fail++; $display("FAIL hu_release_value: got %h expected 00008001", mif.mem_value_bus); end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++; if (mif.mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL hu_drained: got %b expected 0", mif.mem_to_wb_valid); end
    endtask

    task automatic test_discard();
        @(negedge clk);
        mif.exe_to_mem_valid = 1'b1;
        mif.exe_to_mem_bus   = mk_exe(1'b1, 1'b1, 5'd3, 32'h0000_0100, LD_W, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        mif.exe_to_mem_valid = 1'b0;
        mif.wb_exception     = 1'b1;
        @(negedge clk);
        mif.wb_exception = 1'b0;
        #1;
        n_checks++; if (mif.mem_dest_bus !== 5'd0) begin n_fail++; $display("FAIL disc_flushed_dest: got %0d expected 0", mif.mem_dest_bus); end
        n_checks++; if (mif.mem_load_wait !== 1'b0) begin n_fail++; $display("FAIL disc_flushed_wait: got %b expected 0", mif.mem_load_wait); end
        mif.exe_to_mem_valid = 1'b1;
        mif.exe_to_mem_bus   = mk_exe(1'b1, 1'b1, 5'd4, 32'h0000_0200, LD_W, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(mk_wb(1'b1, 1'b1, 5'd4, 32'h0000_BEEF, 1'b0, 1'b0));
        @(negedge clk);
        mif.exe_to_mem_valid  = 1'b0;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h0000_DEAD;
        #1;
        n_checks++; if (mif.mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL disc_stale_valid: got %b expected 0", mif.mem_to_wb_valid); end
        n_checks++; if (mif.mem_load_wait !== 1'b1) begin n_fail++; $display("FAIL disc_stale_wait: got %b expected 1", mif.mem_load_wait); end
        @(negedge clk);
        mif.data_sram_data_ok = 1'b0;
        #1;
        n_checks++; if (mif.mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL disc_gap_valid: got %b expected 0", mif.mem_to_wb_valid); end
        @(negedge clk);
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h0000_BEEF;
        #1;
        n_checks++; if (mif.mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL disc_new_valid: got %b expected 1", mif.mem_to_wb_valid); end
        n_checks++; if (mif.mem_value_bus !== 32'h0000_BEEF) begin n_fail++; $display("FAIL disc_new_value: got %h expected 0000beef", mif.mem_value_bus); end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_load_formats();
        logic [4:0]  ld_t  [6] = '{LD_BU, LD_H, LD_H, LD_B, LD_W, LD_HU};
        logic [1:0]  off_t [6] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [31:0] rd_t  [6] = '{32'h1234_C6AB, 32'h9ABC_0000, 32'h0000_7FFE, 32'h0000_007F, 32'hCAFE_F00D, 32'h1111_FFFE};
        logic [31:0] ex_t  [6] = '{32'h0000_00C6, 32'hFFFF_9ABC, 32'h0000_7FFE, 32'h0000_007F, 32'hCAFE_F00D, 32'h0000_FFFE};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mif.exe_to_mem_valid = 1'b1;
            mif.exe_to_mem_bus   = mk_exe(1'b1, 1'b1, 5'(i + 10), {28'h0000_300, 2'b00, off_t[i]}, ld_t[i], 1'b0, 1'b0, 1'b1);
            exp_q.push_back(mk_wb(1'b1, 1'b1, 5'(i + 10), ex_t[i], 1'b0, 1'b0));
            @(negedge clk);
            mif.exe_to_mem_valid  = 1'b0;
            mif.data_sram_data_ok = 1'b1;
            mif.data_sram_rdata   = rd_t[i];
            #1;
            n_checks++; if (mif.mem_value_bus !== ex_t[i]) begin n_fail++; $display("FAIL fmt_value[%0d]: got %h expected %h", i, mif.mem_value_bus, ex_t[i]); end
            @(negedge clk);
            mif.data_sram_data_ok = 1'b0;
        end
    endtask

    task automatic test_exception();
        @(negedge clk);
        mif.exe_to_mem_valid = 1'b1;
        mif.exe_to_mem_bus   = mk_exe(1'b0, 1'b0, 5'd6, 32'h0000_0003, LD_NONE, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(mk_wb(1'b0, 1'b0, 5'd6, 32'h0000_0003, 1'b0, 1'b1));
        @(negedge clk);
        mif.exe_to_mem_valid = 1'b0;
        #1;
        n_checks++; if (mif.mem_exception !== 1'b1) begin n_fail++; $display("FAIL exc_flag: got %b expected 1", mif.mem_exception); end
        n_checks++; if (mif.mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL exc_pass: got %b expected 1", mif.mem_to_wb_valid); end
        @(negedge clk);
        mif.wb_exception = 1'b1;
        #1;
        n_checks++; if (mif.mem_exception !== 1'b0) begin n_fail++; $display("FAIL exc_gone: got %b expected 0", mif.mem_exception); end
        @(negedge clk);
        mif.wb_exception     = 1'b0;
        mif.wb_allow         = 1'b0;
        mif.exe_to_mem_valid = 1'b1;
        mif.exe_to_mem_bus   = mk_exe(1'b0, 1'b1, 5'd8, 32'h0000_0005, LD_NONE, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        mif.exe_to_mem_valid = 1'b0;
        mif.wb_exception     = 1'b1;
        #1;
        n_checks++; if (mif.mem_exception !== 1'b1) begin n_fail++; $display("FAIL exc_held: got %b expected 1", mif.mem_exception); end
        @(negedge clk);
        mif.wb_exception = 1'b0;
        mif.wb_allow     = 1'b1;
        #1;
        n_checks++; if (mif.mem_exception !== 1'b0) begin n_fail++; $display("FAIL exc_flushed: got %b expected 0", mif.mem_exception); end
        n_checks++; if (mif.mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL exc_flushed_valid: got %b expected 0", mif.mem_to_wb_valid); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] dests [8];
        logic       cres  [8];
        logic [31:0] res;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dests[i] = 5'($urandom_range(1, 31));
            cres[i]  = 1'(i % 2);
            res      = $urandom;
            mif.exe_to_mem_valid = 1'b1;
            mif.exe_to_mem_bus   = mk_exe(1'b0, 1'b1, dests[i], res, LD_NONE, cres[i], 1'b0, 1'b0);
            exp_q.push_back(mk_wb(1'b0, 1'b1, dests[i], res, cres[i], 1'b0));
            #1;
            n_checks++; if (mif.mem_allow !== 1'b1) begin n_fail++; $display("FAIL b2b_allow[%0d]: got %b expected 1", i, mif.mem_allow); end
            if (i > 0) begin
                n_checks++; if (mif.mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, mif.mem_to_wb_valid); end
                n_checks++; if (mif.mem_dest_bus !== dests[i-1]) begin n_fail++; $display("FAIL b2b_dest[%0d]: got %0d expected %0d", i, mif.mem_dest_bus, dests[i-1]); end
                n_checks++; if (mif.mem_csr_re_bus !== cres[i-1]) begin n_fail++; $display("FAIL b2b_csr_re[%0d]: got %b expected %b", i, mif.mem_csr_re_bus, cres[i-1]); end
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++; if (mif.mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_last_valid: got %b expected 1", mif.mem_to_wb_valid); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ld_b_wait();
        test_ld_hu_buffered();
        test_discard();
        test_load_formats();
        test_exception();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d bundles outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
